// File: rtl/alu_exec_pipe_if.sv
// Handshake bundle for the pipelined execute ALU.
// Producer side: in_valid/opcode/in_a/in_b, consumer ready out_ready.
// ALU side: in_ready, out_valid, result, mem_addr, flags {N,V,Z}.
interface alu_exec_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] mem_addr;
    logic [2:0]       flags;

    modport master (
        output in_valid, opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, result, mem_addr, flags
    );

    modport slave (
        input  in_valid, opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, result, mem_addr, flags
    );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage execute ALU: S1 latches operands, S2 latches results.
// Ports: clk, rst_n (async low), flush, bus (alu_exec_pipe_if.slave).
module alu_exec_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    alu_exec_pipe_if.slave   bus
);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_v_q, s1_v_d;
    logic [3:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_res_q, s2_addr_q;
    logic [2:0]       s2_fc_q, s2_fm_q;
    logic [2:0]       flags_q, flags_d;

    logic s1_adv, in_ready, accept, retire;

    assign s1_adv   = !s2_v_q || bus.out_ready;
    assign in_ready = !flush && (!s1_v_q || s1_adv);
    assign accept   = bus.in_valid && in_ready;
    assign retire   = s2_v_q && bus.out_ready;

    // S1 combinational compute
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] red, pad, sll, sra, ror, addr;
    logic [4:0]       lane;
    logic [SHW-1:0]   sh;
    logic [SHW:0]     rsh;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic [2:0]       fm_d, fc_d;

    assign add_w = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
    assign sub_w = {s1_a_q[WIDTH-1], s1_a_q} - {s1_b_q[WIDTH-1], s1_b_q};
    assign sh    = s1_b_q[SHW-1:0];
    assign rsh   = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign sll   = s1_a_q << sh;
    assign sra   = $signed(s1_a_q) >>> sh;
    // rsh == WIDTH when sh == 0, so the left part vanishes
    assign ror   = (s1_a_q >> sh) | (s1_a_q << rsh);
    assign addr  = {s1_a_q[WIDTH-1:1], 1'b0}
                 + {s1_b_q[WIDTH-2:0], 1'b0};

    // Modular sum gives the exact truncated/sign-extended byte total
    always_comb begin
        red = '0;
        for (int i = 0; i < WIDTH/8; i++) begin
            red = red + {{(WIDTH-8){s1_a_q[8*i+7]}}, s1_a_q[8*i +: 8]}
                      + {{(WIDTH-8){s1_b_q[8*i+7]}}, s1_b_q[8*i +: 8]};
        end
    end

    always_comb begin
        pad  = '0;
        lane = '0;
        for (int j = 0; j < WIDTH/4; j++) begin
            lane = {s1_a_q[4*j+3], s1_a_q[4*j +: 4]}
                 + {s1_b_q[4*j+3], s1_b_q[4*j +: 4]};
            if (lane[4] != lane[3])
                pad[4*j +: 4] = lane[4] ? 4'h8 : 4'h7;
            else
                pad[4*j +: 4] = lane[3:0];
        end
    end

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        fm_d  = 3'b000;
        case (s1_op_q)
            4'd0: begin
                ovf_d = add_w[WIDTH] ^ add_w[WIDTH-1];
                res_d = ovf_d ? (add_w[WIDTH] ? SMIN : SMAX)
                              : add_w[WIDTH-1:0];
                fm_d  = 3'b111;
            end
            4'd1: begin
                ovf_d = sub_w[WIDTH] ^ sub_w[WIDTH-1];
                res_d = ovf_d ? (sub_w[WIDTH] ? SMIN : SMAX)
                              : sub_w[WIDTH-1:0];
                fm_d  = 3'b111;
            end
            4'd2: res_d = red;
            4'd3: begin res_d = s1_a_q ^ s1_b_q; fm_d = 3'b001; end
            4'd4: begin res_d = sll; fm_d = 3'b001; end
            4'd5: begin res_d = sra; fm_d = 3'b001; end
            4'd6: begin res_d = ror; fm_d = 3'b001; end
            4'd7: res_d = pad;
            4'd8, 4'd9: res_d = addr;
            default: res_d = '0;
        endcase
        fc_d = {res_d[WIDTH-1], ovf_d, res_d == '0};
    end

    // Valid tracking: a load into S1 also covers the stalled-S2 case
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (accept)      s1_v_d = 1'b1;
            else if (s1_adv) s1_v_d = 1'b0;
            if (s1_adv)      s2_v_d = s1_v_q;
        end
    end

    // A retirement coincident with flush still commits its flags
    always_comb begin
        flags_d = flags_q;
        if (retire)
            flags_d = (flags_q & ~s2_fm_q) | (s2_fc_q & s2_fm_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_op_q   <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s2_v_q    <= 1'b0;
            s2_res_q  <= '0;
            s2_addr_q <= '0;
            s2_fc_q   <= '0;
            s2_fm_q   <= '0;
            flags_q   <= '0;
        end else begin
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
            flags_q <= flags_d;
            if (accept) begin
                s1_op_q <= bus.opcode;
                s1_a_q  <= bus.in_a;
                s1_b_q  <= bus.in_b;
            end
            if (s1_adv && s1_v_q && !flush) begin
                s2_res_q  <= res_d;
                s2_addr_q <= addr;
                s2_fc_q   <= fc_d;
                s2_fm_q   <= fm_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_v_q;
    assign bus.result    = s2_res_q;
    assign bus.mem_addr  = s2_addr_q;
    assign bus.flags     = flags_q;
endmodule
